// File: rtl/kyber_ntt_pkg.sv
// Shared constants, butterfly op encoding and scheduler state encoding for the
// Kyber NTT zeta scheduler.
package kyber_ntt_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;
  localparam int INV_F   = 1441;

  localparam logic [1:0] OP_CT    = 2'd0;
  localparam logic [1:0] OP_GS    = 2'd1;
  localparam logic [1:0] OP_SCALE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } st_e;

endpackage

// File: rtl/ntt_loop_ctr.sv
// Loop counters for one NTT pass: butterfly span len, group start, index j,
// zeta index k and layer number, with group/layer boundary flags.
module ntt_loop_ctr
  import kyber_ntt_pkg::*;
#(
  parameter int COEF_AW = 8,
  parameter int ZETA_AW = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init,
  input  logic               inv,
  input  logic               step,
  input  logic               group_next,
  input  logic               layer_next,
  output logic [COEF_AW-1:0] j,
  output logic [COEF_AW-1:0] addr_b,
  output logic [ZETA_AW-1:0] k,
  output logic               last_in_group,
  output logic               last_in_layer,
  output logic               last_layer
);

  logic [COEF_AW:0]   len_q, len_d, start_q, start_d;
  logic [COEF_AW-1:0] j_q, j_d;
  logic [ZETA_AW-1:0] k_q, k_d;
  logic [2:0]         layer_q, layer_d;
  logic [COEF_AW+1:0] grp_end, grp_last;

  assign grp_end  = {1'b0, start_q} + {len_q, 1'b0};
  assign grp_last = {1'b0, start_q} + {1'b0, len_q} - (COEF_AW+2)'(1);

  assign last_in_group = ({2'b00, j_q} == grp_last);
  assign last_in_layer = (grp_end >= (COEF_AW+2)'(KYBER_N));
  assign last_layer    = (layer_q == 3'd6);

  assign j      = j_q;
  assign k      = k_q;
  assign addr_b = j_q + len_q[COEF_AW-1:0];

  always_comb begin
    len_d   = len_q;
    start_d = start_q;
    j_d     = j_q;
    k_d     = k_q;
    layer_d = layer_q;
    if (init) begin
      len_d   = inv ? (COEF_AW+1)'(2) : (COEF_AW+1)'(KYBER_N/2);
      k_d     = inv ? '1 : ZETA_AW'(1);
      start_d = '0;
      j_d     = '0;
      layer_d = '0;
    end else if (layer_next) begin
      len_d   = inv ? (len_q << 1) : (len_q >> 1);
      start_d = '0;
      j_d     = '0;
      layer_d = layer_q + 3'd1;
    end else if (group_next) begin
      start_d = grp_end[COEF_AW:0];
      j_d     = grp_end[COEF_AW-1:0];
      // The final group of the pass has no successor fetch, so k stays in 1..127.
      if (!(last_in_layer && last_layer))
        k_d = inv ? (k_q - 1'b1) : (k_q + 1'b1);
    end else if (step) begin
      j_d = j_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      start_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      layer_q <= '0;
    end else begin
      len_q   <= len_d;
      start_q <= start_d;
      j_q     <= j_d;
      k_q     <= k_d;
      layer_q <= layer_d;
    end
  end

endmodule

// File: rtl/ntt_zeta_sched.sv
// Kyber NTT / inverse-NTT pass scheduler: zeta ROM fetch, butterfly issue and
// inter-layer drain. Define NTT_SCALE_EN to append the 1/128 scaling phase.
module ntt_zeta_sched
  import kyber_ntt_pkg::*;
#(
  parameter int BF_LAT  = 4,
  parameter int COEF_AW = 8,
  parameter int ZETA_AW = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic               zeta_ce,
  output logic [ZETA_AW-1:0] zeta_ad,
  input  logic [11:0]        zeta_dout,
  output logic               bf_valid,
  input  logic               bf_ready,
  output logic [1:0]         bf_op,
  output logic [COEF_AW-1:0] bf_addr_a,
  output logic [COEF_AW-1:0] bf_addr_b,
  output logic [11:0]        bf_zeta
);

  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  st_e             state_q, state_d;
  logic            mode_q, mode_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            init, step, group_next, layer_next;
  logic            last_in_group, last_in_layer, last_layer;
  logic            scale_ph, issue;
  logic [COEF_AW-1:0] j, addr_b;
  logic [ZETA_AW-1:0] k;

`ifdef NTT_SCALE_EN
  logic scale_q, scale_d;
  assign scale_ph = scale_q;
`else
  assign scale_ph = 1'b0;
`endif

  ntt_loop_ctr #(.COEF_AW(COEF_AW), .ZETA_AW(ZETA_AW)) u_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (init),
    .inv          (mode_d),
    .step         (step),
    .group_next   (group_next),
    .layer_next   (layer_next),
    .j            (j),
    .addr_b       (addr_b),
    .k            (k),
    .last_in_group(last_in_group),
    .last_in_layer(last_in_layer),
    .last_layer   (last_layer)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    drain_d    = drain_q;
    init       = 1'b0;
    step       = 1'b0;
    group_next = 1'b0;
    layer_next = 1'b0;
`ifdef NTT_SCALE_EN
    scale_d    = scale_q;
`endif
    case (state_q)
      ST_IDLE: if (start) begin
        mode_d  = mode;
        init    = 1'b1;
        state_d = ST_FETCH;
`ifdef NTT_SCALE_EN
        scale_d = 1'b0;
`endif
      end
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: if (bf_ready) begin
        step = 1'b1;
        if (scale_ph) begin
          if (j == '1) state_d = ST_DRAIN;
        end else if (last_in_group) begin
          group_next = 1'b1;
          state_d    = last_in_layer ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_DRAIN: if (drain_q == DW'(BF_LAT-1)) begin
        drain_d = '0;
        if (scale_ph) begin
          state_d = ST_DONE;
        end else begin
          layer_next = 1'b1;
          if (!last_layer) begin
            state_d = ST_FETCH;
          end else begin
`ifdef NTT_SCALE_EN
            // Scaling reuses the counters: after the last inverse layer len=256,
            // start=0, j=0, so j simply walks 0..255.
            if (mode_q) begin
              scale_d = 1'b1;
              state_d = ST_ISSUE;
            end else begin
              state_d = ST_DONE;
            end
`else
            state_d = ST_DONE;
`endif
          end
        end
      end else begin
        drain_d = drain_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      drain_q <= '0;
`ifdef NTT_SCALE_EN
      scale_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      drain_q <= drain_d;
`ifdef NTT_SCALE_EN
      scale_q <= scale_d;
`endif
    end
  end

  // Outputs decode from state only, so async reset zeroes them immediately.
  assign issue     = (state_q == ST_ISSUE);
  assign busy      = (state_q == ST_FETCH) || issue || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign zeta_ce   = (state_q == ST_FETCH);
  assign zeta_ad   = zeta_ce ? k : '0;
  assign bf_valid  = issue;
  assign bf_op     = !issue ? OP_CT : scale_ph ? OP_SCALE : mode_q ? OP_GS : OP_CT;
  assign bf_addr_a = issue ? j : '0;
  assign bf_addr_b = !issue ? '0 : scale_ph ? j : addr_b;
  assign bf_zeta   = !issue ? '0 : scale_ph ? 12'(INV_F) : zeta_dout;

endmodule

// File: tb/tb_ntt_zeta_sched.sv
// Directed bench for ntt_zeta_sched: reset, forward/inverse command sequences,
// backpressure, layer drain gaps, latency and mid-pass abort.
module tb_ntt_zeta_sched;
  localparam int BF_LAT = 4;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, bf_ready = 1'b0;
  logic        busy, done, zeta_ce, bf_valid;
  logic [6:0]  zeta_ad;
  logic [11:0] zeta_dout = '0, bf_zeta;
  logic [1:0]  bf_op;
  logic [7:0]  bf_addr_a, bf_addr_b;

  logic [11:0] rom [128];
  int total = 0, bad = 0, done_cnt = 0, n_cmd = 0;
  int ea [1152], eb [1152], ez [1152], eo [1152], ek [127];

  ntt_zeta_sched #(.BF_LAT(BF_LAT), .COEF_AW(8), .ZETA_AW(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
    .zeta_ce(zeta_ce), .zeta_ad(zeta_ad), .zeta_dout(zeta_dout), .bf_valid(bf_valid),
    .bf_ready(bf_ready), .bf_op(bf_op), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .bf_zeta(bf_zeta)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (zeta_ce) zeta_dout <= rom[zeta_ad];
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s obs=%0d want=%0d", tag, obs, want);
    end
  endtask

  // Reference Kyber loop nest: expected fetch addresses and command stream.
  task automatic build(input bit m);
    int kk, idx, f;
    idx = 0; f = 0;
    kk = m ? 127 : 1;
    for (int l = 0; l < 7; l++) begin
      int len;
      len = m ? (2 << l) : (128 >> l);
      for (int s = 0; s < 256; s += 2 * len) begin
        ek[f] = kk; f++;
        for (int jj = s; jj < s + len; jj++) begin
          ea[idx] = jj; eb[idx] = jj + len; ez[idx] = int'(rom[kk]); eo[idx] = m ? 1 : 0;
          idx++;
        end
        kk = m ? kk - 1 : kk + 1;
      end
    end
`ifdef NTT_SCALE_EN
    if (m) for (int jj = 0; jj < 256; jj++) begin
      ea[idx] = jj; eb[idx] = jj; ez[idx] = 1441; eo[idx] = 2; idx++;
    end
`endif
    n_cmd = idx;
  endtask

  // Called just after a negedge; cycle 1 is the cycle in which start is high.
  task automatic run_pass(input bit m, input int bp_at);
    int cyc, nc, nf, gap, stall_left, stalls, exp_lat;
    bit bp_started, prev_stall, fin;
    logic [7:0] pa, pb; logic [11:0] pz; logic [1:0] po;
    build(m);
    start = 1'b1; mode = m; bf_ready = 1'b1;
    cyc = 1; nc = 0; nf = 0; gap = 0; stall_left = 0; stalls = 0;
    bp_started = 0; prev_stall = 0; fin = 0;
    pa = '0; pb = '0; pz = '0; po = '0;
    while (!fin && cyc < 4000) begin
      @(negedge clk); cyc++;
      start = (cyc == 50);
      mode  = (cyc > 2) ? ~m : m;
      if (bp_at >= 0 && !bp_started && nc == bp_at) begin bp_started = 1; stall_left = 10; end
      bf_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (prev_stall) begin
        chk("stall_a", bf_addr_a, pa); chk("stall_b", bf_addr_b, pb);
        chk("stall_z", bf_zeta, pz);   chk("stall_op", bf_op, po);
        chk("stall_valid", bf_valid, 1);
      end
      prev_stall = 0;
      if (done) begin
        fin = 1;
        exp_lat = 127 + 896 + 7 * BF_LAT + 2 + stalls + (n_cmd - 896) + ((n_cmd > 896) ? BF_LAT : 0);
        chk("latency", cyc, exp_lat);
        chk("cmd_count", nc, n_cmd);
        chk("fetch_count", nf, 127);
        chk("busy_at_done", busy, 0);
        chk("final_drain", gap, BF_LAT);
      end else begin
        chk("busy", busy, 1);
        if (zeta_ce) begin
          chk("fetch_ad", zeta_ad, (nf < 127) ? ek[nf] : -1);
          if (nc > 0) chk("layer_gap", gap, (nc % 128 == 0) ? BF_LAT : 0);
          chk("fetch_valid", bf_valid, 0);
          gap = 0; nf++;
        end else if (bf_valid) begin
          if (bf_ready) begin
            if (nc == 896) chk("scale_gap", gap, BF_LAT);
            chk("cmd_a", bf_addr_a, (nc < n_cmd) ? ea[nc] : -1);
            chk("cmd_b", bf_addr_b, (nc < n_cmd) ? eb[nc] : -1);
            chk("cmd_z", bf_zeta, (nc < n_cmd) ? ez[nc] : -1);
            chk("cmd_op", bf_op, (nc < n_cmd) ? eo[nc] : -1);
            gap = 0; nc++;
          end else begin
            chk("stall_ce", zeta_ce, 0);
            stalls++; prev_stall = 1;
            pa = bf_addr_a; pb = bf_addr_b; pz = bf_zeta; po = bf_op;
          end
        end else begin
          gap++;
        end
      end
    end
    chk("done_seen", fin, 1);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    start = 1'b0; mode = 1'b0; bf_ready = 1'b0;
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 128; i++) rom[i] = 12'(i * 29 + 17);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_valid", bf_valid, 0);  chk("rst_ce", zeta_ce, 0);
    chk("rst_ad", zeta_ad, 0);      chk("rst_a", bf_addr_a, 0);
    chk("rst_b", bf_addr_b, 0);     chk("rst_z", bf_zeta, 0);
    chk("rst_op", bf_op, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    run_pass(1'b0, -1);
    run_pass(1'b1, 300);
    run_pass(1'b0, 200);

    // Abort a forward pass during its third layer.
    start = 1'b1; mode = 1'b0; bf_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (330) @(negedge clk);
    chk("abort_busy_pre", busy, 1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);   chk("abort_valid", bf_valid, 0);
    chk("abort_ce", zeta_ce, 0);  chk("abort_ad", zeta_ad, 0);
    chk("abort_a", bf_addr_a, 0); chk("abort_b", bf_addr_b, 0);
    chk("abort_z", bf_zeta, 0);   chk("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", busy, 0);

    run_pass(1'b1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
